// File: rtl/fir_tap_sequencer.sv
// Control/data stage feeding a 3-tap MAC: holds the sample delay line and coefficient bank,
// steps one tap per cycle after each accepted sample and flags when the MAC sum is final.
module fir_tap_sequencer #(
  parameter int unsigned SAMPLE_W = 3,
  parameter int unsigned COEFF_W  = 16
) (
  input  logic                iClk_12M,
  input  logic                iRst,
  input  logic                iEnSample,
  input  logic [SAMPLE_W-1:0] iFirIn,
  input  logic                iCoeffWe,
  input  logic [1:0]          iCoeffAddr,
  input  logic [COEFF_W-1:0]  iCoeffData,
  input  logic                iOvrClr,
  output logic [SAMPLE_W-1:0] oDelay1,
  output logic [SAMPLE_W-1:0] oDelay2,
  output logic [SAMPLE_W-1:0] oDelay3,
  output logic [COEFF_W-1:0]  oCoeff,
  output logic [3:0]          oEnMul,
  output logic                oEnAdd,
  output logic                oEnAcc,
  output logic                oResultValid,
  output logic                oBusy,
  output logic                oOverrun
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TAP1 = 3'd1,
    S_TAP2 = 3'd2,
    S_TAP3 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_drop;
  logic [SAMPLE_W-1:0] r_d1, r_d2, r_d3;
  logic [COEFF_W-1:0]  r_c0, r_c1, r_c2;
  logic                r_overrun;

  // A strobe is accepted only when no tap sequence is running; otherwise it is dropped.
  assign w_accept = iEnSample && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_drop   = iEnSample && !w_accept;

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state plus per-tap decode straight from the registered state.
  always_comb begin
    w_next       = r_state;
    oEnMul       = 4'b0000;
    oCoeff       = '0;
    oEnAdd       = 1'b0;
    oEnAcc       = 1'b0;
    oResultValid = 1'b0;
    oBusy        = 1'b0;
    case (r_state)
      S_IDLE: if (iEnSample) w_next = S_TAP1;
      S_TAP1: begin
        w_next = S_TAP2;
        oEnMul = 4'b0001;
        oCoeff = r_c0;
        oEnAdd = 1'b1;
        oEnAcc = 1'b1;
        oBusy  = 1'b1;
      end
      S_TAP2: begin
        w_next = S_TAP3;
        oEnMul = 4'b0010;
        oCoeff = r_c1;
        oEnAdd = 1'b1;
        oEnAcc = 1'b1;
        oBusy  = 1'b1;
      end
      S_TAP3: begin
        w_next = S_DONE;
        oEnMul = 4'b0011;
        oCoeff = r_c2;
        oEnAdd = 1'b1;
        oEnAcc = 1'b1;
        oBusy  = 1'b1;
      end
      S_DONE: begin
        w_next       = iEnSample ? S_TAP1 : S_IDLE;
        oResultValid = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
    end else if (w_accept) begin
      r_d3 <= r_d2;
      r_d2 <= r_d1;
      r_d1 <= iFirIn;
    end
  end

  // Address 3 is unmapped and silently ignored.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      r_c0 <= '0;
      r_c1 <= '0;
      r_c2 <= '0;
    end else if (iCoeffWe) begin
      case (iCoeffAddr)
        2'd0:    r_c0 <= iCoeffData;
        2'd1:    r_c1 <= iCoeffData;
        2'd2:    r_c2 <= iCoeffData;
        default: ;
      endcase
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst)         r_overrun <= 1'b0;
    else if (w_drop)  r_overrun <= 1'b1;
    else if (iOvrClr) r_overrun <= 1'b0;
  end

  assign oDelay1  = r_d1;
  assign oDelay2  = r_d2;
  assign oDelay3  = r_d3;
  assign oOverrun = r_overrun;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: directed steps, a small MAC model driven by the tap outputs,
// and a queue of expected FIR sums compared whenever the result-valid pulse appears.
module tb_fir_tap_sequencer;

  localparam int unsigned SW = 3;
  localparam int unsigned CW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en_sample;
  logic        [SW-1:0] fir_in;
  logic                 coeff_we;
  logic        [1:0]    coeff_addr;
  logic        [CW-1:0] coeff_data;
  logic                 ovr_clr;
  logic signed [SW-1:0] d1, d2, d3;
  logic signed [CW-1:0] coeff;
  logic        [3:0]    en_mul;
  logic                 en_add, en_acc, valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int                   q_exp[$];
  logic signed [SW-1:0] m_d1, m_d2, m_d3;
  logic signed [CW-1:0] m_bank [3];
  int                   mac_acc;

  fir_tap_sequencer #(.SAMPLE_W(SW), .COEFF_W(CW)) dut (
    .iClk_12M    (clk),
    .iRst        (rst),
    .iEnSample   (en_sample),
    .iFirIn      (fir_in),
    .iCoeffWe    (coeff_we),
    .iCoeffAddr  (coeff_addr),
    .iCoeffData  (coeff_data),
    .iOvrClr     (ovr_clr),
    .oDelay1     (d1),
    .oDelay2     (d2),
    .oDelay3     (d3),
    .oCoeff      (coeff),
    .oEnMul      (en_mul),
    .oEnAdd      (en_add),
    .oEnAcc      (en_acc),
    .oResultValid(valid),
    .oBusy       (busy),
    .oOverrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Downstream MAC model: clears on tap 1, accumulates on taps 2 and 3.
  always @(negedge clk) begin
    int tap;
    if (rst) begin
      mac_acc = 0;
    end else begin
      if (en_acc) begin
        tap = 0;
        if (en_mul == 4'b0001)      tap = d1;
        else if (en_mul == 4'b0010) tap = d2;
        else if (en_mul == 4'b0011) tap = d3;
        mac_acc = ((en_mul == 4'b0001) ? 0 : mac_acc) + tap * int'(coeff);
      end
      if (valid) begin
        if (q_exp.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("mac_result", mac_acc, q_exp.pop_front());
          check("valid_enmul_idle", int'(en_mul), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coeff(input logic [1:0] addr, input int data);
    coeff_we   = 1'b1;
    coeff_addr = addr;
    coeff_data = CW'(data);
    if (addr != 2'd3) m_bank[addr] = CW'(data);
    tick();
    coeff_we = 1'b0;
  endtask

  task automatic check_tap(input int k);
    check($sformatf("tap%0d_enmul", k), int'(en_mul), k);
    check($sformatf("tap%0d_coeff", k), int'(coeff), int'(m_bank[k-1]));
    check($sformatf("tap%0d_en", k), int'({en_add, en_acc, busy, valid}), 4'b1110);
  endtask

  // Strobe one sample and step through TAP1..DONE; returns in the DONE cycle.
  task automatic run_sample(input int s);
    en_sample = 1'b1;
    fir_in    = SW'(s);
    m_d3 = m_d2;
    m_d2 = m_d1;
    m_d1 = SW'(s);
    q_exp.push_back(int'(m_bank[0]) * int'(m_d1) + int'(m_bank[1]) * int'(m_d2)
                    + int'(m_bank[2]) * int'(m_d3));
    tick();
    en_sample = 1'b0;
    check_tap(1);
    check("delays", int'({d1, d2, d3}), int'({m_d1, m_d2, m_d3}));
    tick();
    check_tap(2);
    tick();
    check_tap(3);
    tick();
    check("done_valid", int'({valid, busy, en_add, en_acc}), 4'b1000);
    check("done_coeff", int'(coeff), 0);
  endtask

  initial begin
    rst = 1'b1; en_sample = 1'b0; fir_in = '0; coeff_we = 1'b0;
    coeff_addr = '0; coeff_data = '0; ovr_clr = 1'b0;
    m_d1 = '0; m_d2 = '0; m_d3 = '0;
    for (int i = 0; i < 3; i++) m_bank[i] = '0;
    repeat (3) tick();
    check("reset_outputs", int'({en_mul, en_add, en_acc, valid, busy, overrun}), 0);
    check("reset_delays", int'({d1, d2, d3}), 0);
    rst = 1'b0;
    tick();

    // Abort mid-TAP2: outputs drop at once and the pending result never appears.
    write_coeff(2'd0, 4);
    en_sample = 1'b1; fir_in = SW'(3);
    q_exp.push_back(12);
    tick();
    en_sample = 1'b0;
    tick();
    check("pre_abort_tap2", int'(en_mul), 2);
    rst = 1'b1;
    #1;
    check("abort_outputs", int'({en_mul, en_add, en_acc, valid, busy, overrun}), 0);
    check("abort_coeff_delay", int'({coeff, d1}), 0);
    q_exp.delete();
    m_bank[0] = '0;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // Bank {2,-3,5}, samples 1, 2, -1 spaced apart: sums 2, 1, -3.
    write_coeff(2'd0, 2);
    write_coeff(2'd1, -3);
    write_coeff(2'd2, 5);
    run_sample(1);
    tick(); tick();
    run_sample(2);
    tick(); tick();
    run_sample(-1);
    tick();
    check("idle_after_done", int'({valid, busy, en_mul}), 0);
    check("delays_stable", int'({d1, d2, d3}), int'({m_d1, m_d2, m_d3}));
    tick();

    // Back-to-back: strobe in DONE restarts at TAP1 with no overrun.
    run_sample(3);
    run_sample(-2);
    run_sample(1);
    check("b2b_no_overrun", int'(overrun), 0);
    tick();

    // Overrun: strobe in TAP2 dropped, delay line frozen, flag sticky.
    run_sample(2);
    tick();
    // (re-enter a fresh run so we can hit TAP2 with a strobe)
    en_sample = 1'b1; fir_in = SW'(-3);
    m_d3 = m_d2; m_d2 = m_d1; m_d1 = SW'(-3);
    q_exp.push_back(int'(m_bank[0]) * int'(m_d1) + int'(m_bank[1]) * int'(m_d2)
                    + int'(m_bank[2]) * int'(m_d3));
    tick();
    en_sample = 1'b0;
    tick();
    check("ovr_at_tap2", int'(en_mul), 2);
    en_sample = 1'b1; fir_in = SW'(1);
    tick();
    en_sample = 1'b0;
    check("ovr_set", int'(overrun), 1);
    check("ovr_delays_frozen", int'({d1, d2, d3}), int'({m_d1, m_d2, m_d3}));
    check("ovr_seq_continues", int'(en_mul), 3);
    repeat (3) tick();
    check("ovr_sticky", int'(overrun), 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);

    // Drop again, then clear coincident with another drop: set wins.
    en_sample = 1'b1; fir_in = SW'(0);
    m_d3 = m_d2; m_d2 = m_d1; m_d1 = '0;
    q_exp.push_back(int'(m_bank[1]) * int'(m_d2) + int'(m_bank[2]) * int'(m_d3));
    tick();
    fir_in = SW'(2);
    tick();
    check("ovr_reset_again", int'(overrun), 1);
    ovr_clr = 1'b1;
    tick();
    en_sample = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_beats_clr", int'(overrun), 1);
    check("ovr2_delays_frozen", int'({d1, d2, d3}), int'({m_d1, m_d2, m_d3}));
    repeat (2) tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_final_clear", int'(overrun), 0);

    // Address 3 ignored; bank[1]=7 written in IDLE is used on the next run.
    write_coeff(2'd3, 99);
    write_coeff(2'd1, 7);
    run_sample(-4);
    tick(); tick();

    check("queue_drained", q_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
